pixel_readout_ctrl: RTL and testbench
=====================================

Name: pixel_readout_ctrl

Overview:
Frame-level readout sequencer for the pixel priority-encoder tree. On START it drains every pending hit from the tree, one per iteration:
- enables the address path
- waits for the tree to settle
- captures the winning address into an output FIFO
- pulses the tree clock to clear that pixel

It sits between the pixel array's priority tree (root VALID/ADDR, ADDREI/CLKIN inputs) and the downstream serializer, and applies backpressure via the FIFO.

Parameters:
WID, 8, pixel address width (tree root ADDR width)
SETTLE, 2, cycles (>=1) allowed for tree combinational settling, before capture and after clear
PULSE_W, 1, tree clear-clock high time in cycles (>=1)
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)
CNT_W, 12, hit counter width

Ports:
CLK  input  1  system clock, all logic rising-edge
RSTN  input  1  asynchronous active-low reset
START  input  1  single-cycle frame readout request; ignored while BUSY
BUSY  output  1  high from the cycle after START acceptance until DONE inclusive
DONE  output  1  one-cycle pulse: tree empty, frame finished
TREE_VALID  input  1  root VALID of priority tree
TREE_ADDR  input  WID  root ADDR of priority tree
ADDREI  output  1  address-enable into tree root
CLKOUT  output  1  clear clock into tree root CLKIN
DOUT_VALID  output  1  FIFO not empty
DOUT_READY  input  1  downstream accept
DOUT_ADDR  output  WID  FIFO head address
HIT_CNT  output  CNT_W  hits captured this frame, saturating
OVERFLOW  output  1  sticky: HIT_CNT saturated this frame

Behaviour:
- Reset (RSTN low, async): FSM IDLE, FIFO emptied. All outputs 0, including BUSY, DONE, ADDREI, CLKOUT, DOUT_VALID, DOUT_ADDR, HIT_CNT and OVERFLOW. CLKOUT and ADDREI are registered, so they drop immediately on reset, including mid-pulse.
- States: IDLE, ARM, SETTLE, LATCH, PULSE, RECOVER, FINISH.
- IDLE: ADDREI=0, CLKOUT=0. START=1 → ARM; HIT_CNT and OVERFLOW clear on the same edge.
- ADDREI is registered high in every state except IDLE and FINISH.
- ARM:
  - TREE_VALID=0 → FINISH.
  - TREE_VALID=1 and FIFO full → stay in ARM (stall, no clear pulse).
  - Otherwise → SETTLE. This check reserves the FIFO slot; pops only add space.
- SETTLE: hold SETTLE cycles (down-counter), then → LATCH.
- LATCH (1 cycle):
  - Push TREE_ADDR into the FIFO.
  - HIT_CNT += 1, saturating at all-ones; a saturating increment attempt sets OVERFLOW.
  - → PULSE.
- PULSE: CLKOUT=1 for exactly PULSE_W cycles, then → RECOVER.
- RECOVER: CLKOUT=0 for SETTLE cycles, then → ARM, which re-evaluates TREE_VALID.
- FINISH: DONE=1 for one cycle, ADDREI=0 → IDLE.
- BUSY = (state != IDLE).
- Timing with START sampled at edge 0:
  - ADDREI high at cycle 1.
  - Push at cycle 2+SETTLE; DOUT_VALID visible at cycle 3+SETTLE.
  - CLKOUT high cycles 3+SETTLE .. 2+SETTLE+PULSE_W.
  - Per-hit period = 2+2*SETTLE+PULSE_W cycles (7 at defaults).
- Empty frame: DONE at cycle 2.
- FIFO:
  - First-word-fall-through head; pop on DOUT_VALID & DOUT_READY.
  - Simultaneous push and pop legal at any non-empty level. Push into an empty FIFO is visible next cycle (no bypass).
  - Never overwrites: push only occurs with a slot reserved in ARM.
- TREE_VALID dropping during SETTLE: the capture still proceeds (spurious address possible). The tree contract forbids this and the bench must flag it.
- START during BUSY: no effect. START coincident with FINISH: ignored; a new START is needed in IDLE.
- HIT_CNT and OVERFLOW hold their values after DONE until the next accepted START.

Decomposition:
- Shared include file holding the state encoding localparams (3-bit, IDLE=0) and the default WID/SETTLE/PULSE_W constants used by the pixel-readout hierarchy.
- One sub-module: readout_fifo (sync FIFO, params WID and FIFO_DEPTH; ports CLK, RSTN, push, din, pop, dout, empty, full).
- FSM, counters and CLKOUT/ADDREI registers live in pixel_readout_ctrl.

Test Plan:
- Reset check: hold RSTN=0 with random inputs → all outputs 0. Deassert, idle 10 cycles → no ADDREI/CLKOUT activity.
- Single hit, defaults: tree model holds addr 0x2A, VALID=1 until first CLKOUT edge; START at cycle 0 → ADDREI=1 at cycle 1, DOUT_VALID with DOUT_ADDR=0x2A at cycle 5, CLKOUT high cycle 5 only, DONE at cycle 9, HIT_CNT=1.
- Three hits {0x05, 0x11, 0x80} in priority order, DOUT_READY=1 → outputs in that order, 3 CLKOUT pulses spaced 7 cycles apart, HIT_CNT=3, one DONE pulse.
- Backpressure: 6 hits, DOUT_READY=0 → 4 pushes then a stall in ARM with exactly 4 CLKOUT pulses, DOUT_VALID=1. Raise DOUT_READY → remaining 2 drained, all 6 addresses in order, HIT_CNT=6.
- Empty frame and START while busy: START with TREE_VALID=0 → DONE at cycle 2, HIT_CNT=0. A second START pulsed during a multi-hit frame → no extra DONE, no restart.
- Reset mid-PULSE (PULSE_W=3, RSTN low in the 2nd pulse cycle) → CLKOUT low within the same cycle, FIFO empty, HIT_CNT=0. Also CNT_W=2 with 5 hits → HIT_CNT=3, OVERFLOW=1.

Source files
------------

// File: rtl/pixel_readout_ctrl_pkg.sv
// Shared state encoding and default geometry for the pixel-readout hierarchy.
package pixel_readout_ctrl_pkg;

  localparam int unsigned DEF_WID        = 8;
  localparam int unsigned DEF_SETTLE     = 2;
  localparam int unsigned DEF_PULSE_W    = 1;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_CNT_W      = 12;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_LATCH   = 3'd3,
    ST_PULSE   = 3'd4,
    ST_RECOVER = 3'd5,
    ST_FINISH  = 3'd6
  } state_e;

endpackage

// File: rtl/readout_fifo.sv
// Synchronous first-word-fall-through FIFO for captured pixel addresses.
module readout_fifo #(
  parameter int unsigned WID        = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic           CLK,
  input  logic           RSTN,
  input  logic           push,
  input  logic [WID-1:0] din,
  input  logic           pop,
  output logic [WID-1:0] dout,
  output logic           empty,
  output logic           full
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [WID-1:0] mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Head reads as zero while empty so the output is clean out of reset.
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pixel_readout_ctrl.sv
// Frame readout sequencer: drains the pixel priority tree one hit per iteration
// into an output FIFO, driving the tree address-enable and clear clock.
module pixel_readout_ctrl
  import pixel_readout_ctrl_pkg::*;
#(
  parameter int unsigned WID        = DEF_WID,
  parameter int unsigned SETTLE     = DEF_SETTLE,
  parameter int unsigned PULSE_W    = DEF_PULSE_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  input  logic             TREE_VALID,
  input  logic [WID-1:0]   TREE_ADDR,
  output logic             ADDREI,
  output logic             CLKOUT,
  output logic             DOUT_VALID,
  input  logic             DOUT_READY,
  output logic [WID-1:0]   DOUT_ADDR,
  output logic [CNT_W-1:0] HIT_CNT,
  output logic             OVERFLOW
);

  localparam int unsigned TMAX = (SETTLE > PULSE_W) ? SETTLE : PULSE_W;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_e        state;
  state_e        state_nxt;
  logic [TW-1:0] tmr;
  logic [TW-1:0] tmr_nxt;
  logic          push_c;
  logic          pop_c;
  logic          fifo_empty;
  logic          fifo_full;

  readout_fifo #(
    .WID       (WID),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CLK  (CLK),
    .RSTN (RSTN),
    .push (push_c),
    .din  (TREE_ADDR),
    .pop  (pop_c),
    .dout (DOUT_ADDR),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  assign DOUT_VALID = ~fifo_empty;
  assign pop_c      = DOUT_VALID & DOUT_READY;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= ST_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
    end
  end

  // Next state; the ARM full-check reserves the slot that LATCH later fills.
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    push_c    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (START) state_nxt = ST_ARM;
      end
      ST_ARM: begin
        if (!TREE_VALID) begin
          state_nxt = ST_FINISH;
        end else if (!fifo_full) begin
          state_nxt = ST_SETTLE;
          tmr_nxt   = TW'(SETTLE - 1);
        end
      end
      ST_SETTLE: begin
        if (tmr == '0) state_nxt = ST_LATCH;
        else           tmr_nxt   = tmr - TW'(1);
      end
      ST_LATCH: begin
        push_c    = 1'b1;
        state_nxt = ST_PULSE;
        tmr_nxt   = TW'(PULSE_W - 1);
      end
      ST_PULSE: begin
        if (tmr == '0) begin
          state_nxt = ST_RECOVER;
          tmr_nxt   = TW'(SETTLE - 1);
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end
      ST_RECOVER: begin
        if (tmr == '0) state_nxt = ST_ARM;
        else           tmr_nxt   = tmr - TW'(1);
      end
      ST_FINISH: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Tree-facing strobes are registered from the next state so they track it exactly.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ADDREI   <= 1'b0;
      CLKOUT   <= 1'b0;
      HIT_CNT  <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      BUSY   <= (state_nxt != ST_IDLE);
      DONE   <= (state_nxt == ST_FINISH);
      ADDREI <= (state_nxt != ST_IDLE) && (state_nxt != ST_FINISH);
      CLKOUT <= (state_nxt == ST_PULSE);
      if ((state == ST_IDLE) && START) begin
        HIT_CNT  <= '0;
        OVERFLOW <= 1'b0;
      end else if (push_c) begin
        if (&HIT_CNT) OVERFLOW <= 1'b1;
        else          HIT_CNT  <= HIT_CNT + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Self-checking bench for pixel_readout_ctrl: cycle vectors, a queue-based tree
// model with an in-order scoreboard, and hand sequences for reset and saturation.
module tb_pixel_readout_ctrl;

  localparam int PER  = 7;   // per-hit period at SETTLE=2, PULSE_W=1
  localparam int A_PW = 3;   // clear-pulse width of the alternate instance

  logic       clk;
  logic       d_rstn, d_start, d_tv, d_ready;
  logic [7:0] d_taddr, d_daddr;
  logic       d_busy, d_done, d_addrei, d_clkout, d_dv, d_ovf;
  logic [11:0] d_hit;

  logic       a_rstn, a_start, a_tv, a_ready;
  logic [7:0] a_taddr, a_daddr;
  logic       a_busy, a_done, a_addrei, a_clkout, a_dv, a_ovf;
  logic [1:0] a_hit;

  pixel_readout_ctrl u_dut (
    .CLK(clk), .RSTN(d_rstn), .START(d_start), .BUSY(d_busy), .DONE(d_done),
    .TREE_VALID(d_tv), .TREE_ADDR(d_taddr), .ADDREI(d_addrei), .CLKOUT(d_clkout),
    .DOUT_VALID(d_dv), .DOUT_READY(d_ready), .DOUT_ADDR(d_daddr),
    .HIT_CNT(d_hit), .OVERFLOW(d_ovf)
  );

  pixel_readout_ctrl #(.PULSE_W(A_PW), .CNT_W(2)) u_alt (
    .CLK(clk), .RSTN(a_rstn), .START(a_start), .BUSY(a_busy), .DONE(a_done),
    .TREE_VALID(a_tv), .TREE_ADDR(a_taddr), .ADDREI(a_addrei), .CLKOUT(a_clkout),
    .DOUT_VALID(a_dv), .DOUT_READY(a_ready), .DOUT_ADDR(a_daddr),
    .HIT_CNT(a_hit), .OVERFLOW(a_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        start;
    logic        tv;
    logic [7:0]  taddr;
    logic [4:0]  ctl;    // {busy, done, addrei, clkout, dout_valid}
    logic [7:0]  daddr;
    logic [11:0] hit;
  } vec_t;

  vec_t vtab [15];

  int n_tests, n_fail;
  int cyc, done_cyc;
  int d_pulses, d_dones, d_hi, a_pulses, a_dones, a_hi, a_pend;
  logic d_ck_q, a_ck_q;
  bit use_model;
  logic [7:0] tq[$];
  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  int rise_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: record handshakes, advance to just after the edge, update tree models.
  task automatic tick();
    bit d_rose, a_rose;
    if (d_dv && d_ready) got.push_back(d_daddr);
    @(posedge clk);
    #1;
    cyc++;
    d_rose = d_clkout && !d_ck_q;
    a_rose = a_clkout && !a_ck_q;
    if (d_rose) begin
      d_pulses++;
      rise_cyc.push_back(cyc);
    end
    if (a_rose) a_pulses++;
    if (d_done) begin
      d_dones++;
      done_cyc = cyc;
    end
    if (a_done) a_dones++;
    if (d_clkout) d_hi++;
    else if (d_hi != 0) begin
      check("d_pulse_width", 32'(d_hi), 32'd1);
      d_hi = 0;
    end
    if (!a_rstn) a_hi = 0;
    else if (a_clkout) a_hi++;
    else if (a_hi != 0) begin
      check("a_pulse_width", 32'(a_hi), 32'(A_PW));
      a_hi = 0;
    end
    if (use_model) begin
      if (d_rose && tq.size() > 0) void'(tq.pop_front());
      d_tv    = (tq.size() != 0);
      d_taddr = d_tv ? tq[0] : 8'h00;
    end
    if (a_rose && a_pend > 0) a_pend--;
    a_tv    = (a_pend != 0);
    a_taddr = 8'(64 + a_pend);
    d_ck_q  = d_clkout;
    a_ck_q  = a_clkout;
  endtask

  // Run one frame drawn from exp_q through the tree model and score it.
  task automatic run_frame(input string tag, input int ready_pct, input int hold, input int mid_start);
    int n, t0;
    bit fin;
    n = exp_q.size();
    tq = exp_q;
    got.delete();
    rise_cyc.delete();
    d_pulses = 0;
    d_dones  = 0;
    done_cyc = -1;
    d_tv     = (tq.size() != 0);
    d_taddr  = d_tv ? tq[0] : 8'h00;
    d_ready  = (hold == 0);
    d_start  = 1'b1;
    t0  = cyc;
    fin = 0;
    for (int i = 0; i < 3000 && !fin; i++) begin
      tick();
      d_start = (mid_start != 0) && ((cyc - t0) == mid_start);
      if (hold != 0 && (cyc - t0) == hold) begin
        check($sformatf("%s_stall_pulses", tag), 32'(d_pulses), 32'd4);
        check($sformatf("%s_stall_ctl", tag),
              32'({d_busy, d_done, d_addrei, d_clkout, d_dv}), 32'b10101);
      end
      if ((cyc - t0) >= hold) d_ready = ($urandom_range(99) < ready_pct);
      if (d_done) fin = 1;
    end
    check($sformatf("%s_done_seen", tag), 32'(fin), 32'd1);
    // A START landing on the FINISH cycle must not launch another frame.
    d_start = 1'b1;
    d_ready = 1'b1;
    tick();
    d_start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check($sformatf("%s_idle_after", tag), 32'({d_busy, d_dv}), 32'd0);
    check($sformatf("%s_out_count", tag), 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++)
      check($sformatf("%s_out%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    check($sformatf("%s_pulses", tag), 32'(d_pulses), 32'(n));
    check($sformatf("%s_dones", tag), 32'(d_dones), 32'd1);
    check($sformatf("%s_hit_cnt", tag), 32'(d_hit), 32'(n));
    check($sformatf("%s_overflow", tag), 32'(d_ovf), 32'd0);
    if (ready_pct == 100 && hold == 0) begin
      check($sformatf("%s_done_time", tag), 32'(done_cyc - t0), 32'(2 + PER * n));
      for (int i = 1; i < rise_cyc.size(); i++)
        check($sformatf("%s_spacing%0d", tag, i), 32'(rise_cyc[i] - rise_cyc[i-1]), 32'(PER));
    end
  endtask

  initial begin
    int n;
    logic [31:0] act;
    n_tests = 0; n_fail = 0; cyc = 0; done_cyc = -1;
    d_pulses = 0; d_dones = 0; d_hi = 0; a_pulses = 0; a_dones = 0; a_hi = 0; a_pend = 0;
    d_ck_q = 1'b0; a_ck_q = 1'b0; use_model = 0;

    // Single hit at 0x2A, then an empty frame; one row per cycle.
    vtab[0]  = '{1'b1, 1'b1, 8'h2A, 5'b00000, 8'h00, 12'd0};
    vtab[1]  = '{1'b0, 1'b1, 8'h2A, 5'b10100, 8'h00, 12'd0};
    vtab[2]  = '{1'b0, 1'b1, 8'h2A, 5'b10100, 8'h00, 12'd0};
    vtab[3]  = '{1'b0, 1'b1, 8'h2A, 5'b10100, 8'h00, 12'd0};
    vtab[4]  = '{1'b0, 1'b1, 8'h2A, 5'b10100, 8'h00, 12'd0};
    vtab[5]  = '{1'b0, 1'b0, 8'h00, 5'b10111, 8'h2A, 12'd1};
    vtab[6]  = '{1'b0, 1'b0, 8'h00, 5'b10100, 8'h00, 12'd1};
    vtab[7]  = '{1'b0, 1'b0, 8'h00, 5'b10100, 8'h00, 12'd1};
    vtab[8]  = '{1'b0, 1'b0, 8'h00, 5'b10100, 8'h00, 12'd1};
    vtab[9]  = '{1'b0, 1'b0, 8'h00, 5'b11000, 8'h00, 12'd1};
    vtab[10] = '{1'b0, 1'b0, 8'h00, 5'b00000, 8'h00, 12'd1};
    vtab[11] = '{1'b1, 1'b0, 8'h00, 5'b00000, 8'h00, 12'd1};
    vtab[12] = '{1'b0, 1'b0, 8'h00, 5'b10100, 8'h00, 12'd0};
    vtab[13] = '{1'b0, 1'b0, 8'h00, 5'b11000, 8'h00, 12'd0};
    vtab[14] = '{1'b0, 1'b0, 8'h00, 5'b00000, 8'h00, 12'd0};

    // Reset with random inputs: every output held at zero.
    d_rstn = 1'b0;
    a_rstn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d_start = 1'($urandom); d_tv = 1'($urandom); d_taddr = 8'($urandom); d_ready = 1'($urandom);
      a_start = 1'($urandom); a_tv = 1'($urandom); a_taddr = 8'($urandom); a_ready = 1'($urandom);
      @(posedge clk);
      #1;
      check("rst_outputs", 32'({d_busy, d_done, d_addrei, d_clkout, d_dv, d_daddr, d_hit, d_ovf}), 32'd0);
      check("rst_outputs_alt", 32'({a_busy, a_done, a_addrei, a_clkout, a_dv, a_daddr, a_hit, a_ovf}), 32'd0);
    end
    d_start = 1'b0; d_tv = 1'b0; d_taddr = 8'h00; d_ready = 1'b1;
    a_start = 1'b0; a_ready = 1'b1;
    d_rstn = 1'b1;
    a_rstn = 1'b1;
    act = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      act = act | 32'({d_addrei, d_clkout, d_busy, a_addrei, a_clkout, a_busy});
    end
    check("idle_quiet", act, 32'd0);

    // Vector table.
    for (int i = 0; i < 15; i++) begin
      d_start = vtab[i].start;
      d_tv    = vtab[i].tv;
      d_taddr = vtab[i].taddr;
      check($sformatf("vec%0d_ctl", i), 32'({d_busy, d_done, d_addrei, d_clkout, d_dv}), 32'(vtab[i].ctl));
      if (vtab[i].ctl[0]) check($sformatf("vec%0d_addr", i), 32'(d_daddr), 32'(vtab[i].daddr));
      check($sformatf("vec%0d_hit", i), 32'(d_hit), 32'(vtab[i].hit));
      tick();
    end
    d_start = 1'b0;

    // Model-driven frames.
    use_model = 1;
    exp_q = '{8'h05, 8'h11, 8'h80};
    run_frame("three", 100, 0, 0);
    run_frame("restart", 100, 0, 10);
    exp_q = '{8'h3C, 8'h01, 8'hFE, 8'h77, 8'h42, 8'h9A};
    run_frame("backpressure", 100, 40, 0);
    exp_q.delete();
    run_frame("empty", 100, 0, 0);
    for (int f = 0; f < 12; f++) begin
      exp_q.delete();
      n = int'($urandom_range(7, 0));
      for (int i = 0; i < n; i++) exp_q.push_back(8'($urandom));
      run_frame($sformatf("rnd%0d", f), (f % 3 == 0) ? 100 : ((f % 3 == 1) ? 60 : 20), 0, 0);
    end

    // Alternate instance: reset in the second cycle of a 3-cycle clear pulse.
    a_pend = 2; a_tv = 1'b1; a_ready = 1'b0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < 40 && !a_clkout; i++) tick();
    check("alt_pulse_seen", 32'(a_clkout), 32'd1);
    tick();
    check("alt_pulse_2nd", 32'({a_clkout, a_dv}), 32'b11);
    a_rstn = 1'b0;
    #1;
    check("alt_rst_clkout", 32'(a_clkout), 32'd0);
    check("alt_rst_state", 32'({a_busy, a_addrei, a_dv, a_daddr, a_hit, a_ovf}), 32'd0);
    tick();
    tick();
    a_rstn = 1'b1;
    tick();

    // Alternate instance: 2-bit counter saturates at 3 across 5 hits.
    a_pend = 5; a_tv = 1'b1; a_ready = 1'b1;
    a_pulses = 0; a_dones = 0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < 400 && a_dones == 0; i++) tick();
    tick();
    check("alt_dones", 32'(a_dones), 32'd1);
    check("alt_pulses", 32'(a_pulses), 32'd5);
    check("alt_hit_sat", 32'(a_hit), 32'd3);
    check("alt_overflow", 32'(a_ovf), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
